gcd_requester: RTL and testbench
================================

# gcd_requester

Initiator for the GCD request/response interface. Generates operand pairs from an internal 16-bit LFSR, packs each pair onto the 32-bit request channel with a valid/ready handshake, and captures the 16-bit result. It runs a programmed number of jobs and folds every result into a signature register. It sits in front of `GCD` in self-test and bring-up builds, driving `GCD`'s `in_*` ports and consuming its `out_*` ports.

## Interface
- `SEED`, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'h0001.
- `TIMEOUT`, 255, maximum number of WAIT cycles per job; used only with `GCD_REQ_TIMEOUT_EN`.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run; sampled only in IDLE or DONE.
- `num_jobs`  in  8  job count; captured on an accepted `start`.
- `req_valid`  out  1  request valid; connects to GCD `in_valid`.
- `req_data`  out  32  request; {a[15:0], b[15:0]}; connects to GCD `in_data`.
- `req_ready`  in  1  connects to GCD `in_ready`.
- `rsp_valid`  in  1  connects to GCD `out_valid`.
- `rsp_data`  in  16  connects to GCD `out_data`.
- `busy`  out  1  high in ISSUE or WAIT.
- `done`  out  1  high in DONE; held until the next accepted `start` or `reset`.
- `jobs_done`  out  8  results captured in the current run.
- `last_result`  out  16  most recently captured result.
- `signature`  out  16  result signature.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- **LFSR:** 16-bit Fibonacci, shift left, feedback = s[15]^s[13]^s[12]^s[10]. Operand a = current state; b = state after one step. Both operands are always nonzero.
- **IDLE:**
  - Accepted `start` with `num_jobs`≠0: latch `num_jobs`, clear `jobs_done`, `signature` and `timeout_err`, go to ISSUE.
  - Accepted `start` with `num_jobs`=0: clear the same registers, go to DONE.
- **ISSUE:**
  - `req_valid`=1 and `req_data`={a,b}; `req_data` is held stable until the handshake.
  - The handshake is `req_valid`&&`req_ready`. In the handshake cycle, advance the LFSR two steps, clear `seen_low`, go to WAIT.
- **WAIT:**
  - `req_valid`=0.
  - Set `seen_low` whenever `rsp_valid` is sampled 0.
  - Capture when `rsp_valid`=1 and `seen_low`=1:
    - `last_result`←`rsp_data`
    - `signature`←{`signature`[14:0],`signature`[15]} ^ `rsp_data`
    - `jobs_done`++
  - After a capture: go to DONE if `jobs_done`+1 == latched count, otherwise go to ISSUE.
- **DONE:** `done`=1. An accepted `start` behaves as it does in IDLE.
- **Protocol rule:** the responder deasserts `rsp_valid` for at least one cycle after accepting a request. The `seen_low` flag guarantees a stale result is never captured.
- **Ignored inputs:** `rsp_valid` outside WAIT is ignored. `start` in ISSUE or WAIT is ignored.
- **LFSR across runs:** the LFSR is not reseeded between runs; only `reset` reloads `SEED`.
- **Reset mid-run:** `reset` at any time returns to IDLE. The in-flight request is abandoned and `req_valid` drops in the next cycle.
- **Reset values:** `req_valid`=0, `req_data`=0, `busy`=0, `done`=0, `jobs_done`=0, `last_result`=0, `signature`=0, `timeout_err`=0, LFSR=`SEED`.

## Timing
- `start` accepted in cycle T: `req_valid`=1 from T+1.
- Handshake in cycle H: WAIT from H+1. The earliest possible capture is H+2, because `seen_low` must be set first.
- Capture in cycle C with jobs remaining: next `req_valid` at C+1.
- Capture of the last job in cycle C: `done`=1 and `busy`=0 from C+1.
- At most one request is outstanding; there is no pipelining.

## Configuration
- **`GCD_REQ_TIMEOUT_EN` defined:**
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When the counter reaches `TIMEOUT` without a capture: set `timeout_err`, go to DONE.
  - `jobs_done` keeps its value.
- **`GCD_REQ_TIMEOUT_EN` undefined:**
  - No counter is built and `timeout_err` is tied to 0.
  - WAIT waits indefinitely.

## Test plan
- **Single job.** `SEED`=16'h0001, `num_jobs`=1, ideal GCD stub → `req_data`=32'h0001_0002; `last_result`=1, `signature`=16'h0001, `jobs_done`=1, `done`=1.
- **Two jobs.** `SEED`=16'h0001, `num_jobs`=2, stub responds with a constant 16'h0010 → second `req_data`=32'h0004_0008; `signature`=16'h0030 (0x0010 rotated, then ^0x0010); `jobs_done`=2.
- **Stale response held high.** `rsp_valid` held high through the handshake and the first WAIT cycle, then low 1 cycle, then high with 16'h0007 → exactly one capture; `last_result`=7.
- **Zero jobs and `start` while busy.** `num_jobs`=0 → `done` at T+1 with no `req_valid`. `start` asserted while busy → no effect on the run or counters.
- **Backpressure and reset.** `req_ready`=0 for 5 cycles → `req_data` is stable and `req_valid` stays high. `reset` asserted in WAIT → every output returns to its reset value the next cycle.
- **Timeout (`GCD_REQ_TIMEOUT_EN` defined, `TIMEOUT`=4).** No response → `timeout_err`=1, DONE after 4 WAIT cycles, `jobs_done`=0. Undefined macro → still in WAIT and `timeout_err`=0 after 100 cycles.

Source files
------------

// File: rtl/gcd_requester.sv
// gcd_requester: LFSR-driven initiator for the GCD request/response channel.
// Define GCD_REQ_TIMEOUT_EN to build the per-job WAIT timeout and timeout_err.
module gcd_requester #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_jobs,
    output logic        req_valid,
    output logic [31:0] req_data,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  jobs_done,
    output logic [15:0] last_result,
    output logic [15:0] signature,
    output logic        timeout_err
);

    // state   | meaning
    // S_IDLE  | after reset, waiting for start
    // S_ISSUE | request {a,b} presented until req_ready
    // S_WAIT  | request accepted, waiting for a fresh response
    // S_DONE  | run finished (or timed out), done held
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_1;
    logic [15:0] lfsr_2;
    logic [7:0]  job_count;
    logic        seen_low;
    logic        accept;
    logic        handshake;
    logic        capture;
    logic        last_job;
    logic        expire;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign lfsr_1    = lfsr_step(lfsr);
    assign lfsr_2    = lfsr_step(lfsr_1);
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign handshake = (state == S_ISSUE) && req_ready;
    // seen_low rejects a response level left over from the previous job
    assign capture   = (state == S_WAIT) && rsp_valid && seen_low;
    assign last_job  = (jobs_done + 8'd1) == job_count;

    assign req_valid = (state == S_ISSUE);
    assign req_data  = req_valid ? {lfsr, lfsr_1} : 32'h0000_0000;
    assign busy      = (state == S_ISSUE) || (state == S_WAIT);
    assign done      = (state == S_DONE);

`ifdef GCD_REQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          timeout_q;

    assign expire      = (state == S_WAIT) && !capture && (wait_cnt == TW'(TIMEOUT - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (handshake)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + TW'(1);
            if (accept)
                timeout_q <= 1'b0;
            else if (expire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            lfsr        <= SEED_INIT;
            job_count   <= 8'd0;
            jobs_done   <= 8'd0;
            last_result <= 16'h0000;
            signature   <= 16'h0000;
            seen_low    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        job_count <= num_jobs;
                        jobs_done <= 8'd0;
                        signature <= 16'h0000;
                        state     <= (num_jobs == 8'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        lfsr     <= lfsr_2;
                        seen_low <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        last_result <= rsp_data;
                        signature   <= {signature[14:0], signature[15]} ^ rsp_data;
                        jobs_done   <= jobs_done + 8'd1;
                        state       <= last_job ? S_DONE : S_ISSUE;
                    end else begin
                        if (!rsp_valid)
                            seen_low <= 1'b1;
                        if (expire)
                            state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: table-driven runs against a GCD stub and scoreboard,
// plus hand-written sequences for stale responses, backpressure, reset and timeout.
module tb_gcd_requester;
    localparam logic [15:0] SEED    = 16'h0001;
    localparam int          TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_jobs;
    logic        req_valid;
    logic [31:0] req_data;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        done;
    logic [7:0]  jobs_done;
    logic [15:0] last_result;
    logic [15:0] signature;
    logic        timeout_err;

    gcd_requester #(.SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .num_jobs(num_jobs),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .done(done),
        .jobs_done(jobs_done), .last_result(last_result), .signature(signature),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rsp_mode = 0;   // 0 manual, 1 ideal GCD stub, 2 constant 16'h0010 stub
    int run_id = 0;

    logic        stub_valid = 1'b0;
    logic [15:0] stub_data = 16'h0000;
    logic        man_valid;
    logic [15:0] man_data;
    assign rsp_valid = (rsp_mode != 0) ? stub_valid : man_valid;
    assign rsp_data  = (rsp_mode != 0) ? stub_data  : man_data;

    logic [15:0] lfsr_m;
    logic [15:0] sig_model;
    logic [15:0] exp_q[$];
    logic [31:0] req_log[$];

    typedef struct {
        logic        do_reset;
        int          mode;
        logic [7:0]  num_jobs;
        logic [7:0]  exp_jobs;
        logic        use_sig;
        logic [15:0] exp_sig;
        logic [31:0] exp_last_req;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] gcd16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = x;
        b = y;
        while (b != 16'h0000) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, req_valid, 1'b0);
        check({tag, "_req_data"}, req_data, 32'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_jobs_done"}, jobs_done, 8'd0);
        check({tag, "_last_result"}, last_result, 16'h0);
        check({tag, "_signature"}, signature, 16'h0);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    // Reference LFSR: reloads on reset, advances two steps per accepted request
    always @(posedge clk) begin
        if (reset)
            lfsr_m <= SEED;
        else if (req_valid && req_ready)
            lfsr_m <= step(step(lfsr_m));
    end

    // GCD stub: logs and checks each request, pushes the expected result, answers later
    initial begin
        logic [31:0] d;
        logic [15:0] r;
        forever begin
            @(negedge clk);
            while (rsp_mode != 0 && req_valid) begin
                d = req_data;
                check("req_data", d, {lfsr_m, step(lfsr_m)});
                req_log.push_back(d);
                r = (rsp_mode == 1) ? gcd16(d[31:16], d[15:0]) : 16'h0010;
                exp_q.push_back(r);
                repeat (2 + $urandom_range(0, 2)) @(negedge clk);
                stub_data  = r;
                stub_valid = 1'b1;
                @(negedge clk);
                stub_valid = 1'b0;
            end
        end
    end

    // Scoreboard: each jobs_done increment pops one expected result
    initial begin
        int prev;
        int seen_run;
        logic [15:0] e;
        prev = 0;
        seen_run = 0;
        sig_model = 16'h0000;
        forever begin
            @(negedge clk);
            if (run_id != seen_run) begin
                seen_run  = run_id;
                sig_model = 16'h0000;
            end
            if (rsp_mode != 0 && int'(jobs_done) == prev + 1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_capture", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("last_result", last_result, e);
                    sig_model = {sig_model[14:0], sig_model[15]} ^ e;
                    check("signature_step", signature, sig_model);
                end
            end
            prev = int'(jobs_done);
        end
    end

    task automatic run_row(input int idx);
        vec_t v;
        int base;
        int n;
        v = vecs[idx];
        if (v.do_reset) do_reset();
        req_ready = 1'b1;
        rsp_mode = v.mode;
        base = req_log.size();
        tick();
        start = 1'b1;
        num_jobs = v.num_jobs;
        run_id++;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 4000) begin
            tick();
            n++;
        end
        tick();
        check("row_done", done, 1'b1);
        check("row_busy", busy, 1'b0);
        check("row_jobs_done", jobs_done, v.exp_jobs);
        check("row_req_count", req_log.size() - base, 32'(v.exp_jobs));
        check("row_queue_empty", exp_q.size(), 0);
        check("row_signature", signature, sig_model);
        if (v.use_sig) check("row_signature_const", signature, v.exp_sig);
        if (v.exp_last_req != 32'h0 && req_log.size() > 0)
            check("row_last_req", req_log[req_log.size() - 1], v.exp_last_req);
        rsp_mode = 0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_jobs = 8'd0;
        req_ready = 1'b0;
        man_valid = 1'b0;
        man_data = 16'h0000;

        vecs[0] = '{1'b1, 1, 8'd1,  8'd1,  1'b1, 16'h0001, 32'h0001_0002};
        vecs[1] = '{1'b1, 2, 8'd2,  8'd2,  1'b1, 16'h0030, 32'h0004_0008};
        vecs[2] = '{1'b1, 1, 8'd5,  8'd5,  1'b0, 16'h0000, 32'h0100_0200};
        vecs[3] = '{1'b0, 1, 8'd3,  8'd3,  1'b0, 16'h0000, 32'h400B_8016};
        vecs[4] = '{1'b0, 1, 8'd0,  8'd0,  1'b0, 16'h0000, 32'h0000_0000};
        vecs[5] = '{1'b0, 1, 8'd20, 8'd20, 1'b0, 16'h0000, 32'h0000_0000};

        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_row(i);

        // Zero jobs: done one cycle after start, no request issued, done held
        start = 1'b1;
        num_jobs = 8'd0;
        tick();
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_jobs_cleared", jobs_done, 8'd0);
        check("zero_sig_cleared", signature, 16'h0);
        for (int i = 0; i < 3; i++) begin
            check("zero_no_req", req_valid, 1'b0);
            check("zero_done_held", done, 1'b1);
            tick();
        end

        // Stale response held high across the handshake; start ignored while busy
        do_reset();
        man_valid = 1'b1;
        man_data = 16'h0099;
        req_ready = 1'b1;
        start = 1'b1;
        num_jobs = 8'd1;
        tick();
        start = 1'b0;
        check("stale_req_valid_t1", req_valid, 1'b1);
        check("stale_req_data", req_data, 32'h0001_0002);
        tick();
        check("stale_in_wait", busy, 1'b1);
        check("stale_wait_no_valid", req_valid, 1'b0);
        start = 1'b1;
        num_jobs = 8'd9;
        tick();
        start = 1'b0;
        check("stale_not_captured", jobs_done, 8'd0);
        check("busy_start_ignored", busy, 1'b1);
        man_valid = 1'b0;
        tick();
        man_valid = 1'b1;
        man_data = 16'h0007;
        tick();
        check("stale_capture_count", jobs_done, 8'd1);
        check("stale_last_result", last_result, 16'h0007);
        check("stale_signature", signature, 16'h0007);
        check("stale_done", done, 1'b1);
        tick();
        tick();
        check("stale_single_capture", jobs_done, 8'd1);
        man_valid = 1'b0;

        // Backpressure (LFSR continues), then reset while in WAIT
        req_ready = 1'b0;
        start = 1'b1;
        num_jobs = 8'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_valid", req_valid, 1'b1);
            check("bp_req_data", req_data, 32'h0004_0008);
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("bp_wait_busy", busy, 1'b1);
        check("bp_wait_req_valid", req_valid, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrun");
        reset = 1'b0;
        tick();

        // Timeout behaviour with no response at all
        man_valid = 1'b0;
        req_ready = 1'b1;
        start = 1'b1;
        num_jobs = 8'd3;
        tick();
        start = 1'b0;
        tick();
        req_ready = 1'b0;
        check("to_in_wait", busy, 1'b1);
`ifdef GCD_REQ_TIMEOUT_EN
        repeat (3) tick();
        check("to_still_wait", busy, 1'b1);
        check("to_not_done_yet", done, 1'b0);
        tick();
        check("to_done", done, 1'b1);
        check("to_err", timeout_err, 1'b1);
        check("to_jobs_done", jobs_done, 8'd0);
        start = 1'b1;
        num_jobs = 8'd0;
        tick();
        start = 1'b0;
        check("to_err_cleared", timeout_err, 1'b0);
`else
        repeat (100) tick();
        check("nto_still_wait", busy, 1'b1);
        check("nto_not_done", done, 1'b0);
        check("nto_err", timeout_err, 1'b0);
        check("nto_no_req", req_valid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
